// File: rtl/merge2_arbiter_if.sv
// Two-input flit merge bundle: upstream decoder channels In0/In1, merged Out channel and Locked flag.
// master drives the upstream flits and Out_ready; slave is the arbiter side.
interface merge2_arbiter_if #(
  parameter int W = 9
);
  logic [W-1:0] In0_data;
  logic         In0_valid;
  logic         In0_ready;
  logic [W-1:0] In1_data;
  logic         In1_valid;
  logic         In1_ready;
  logic [W-1:0] Out_data;
  logic         Out_valid;
  logic         Out_ready;
  logic         Locked;

  modport master (
    output In0_data, In0_valid, In1_data, In1_valid, Out_ready,
    input  In0_ready, In1_ready, Out_data, Out_valid, Locked
  );

  modport slave (
    input  In0_data, In0_valid, In1_data, In1_valid, Out_ready,
    output In0_ready, In1_ready, Out_data, Out_valid, Locked
  );
endinterface

// File: rtl/merge2_arbiter.sv
// Purpose: packet-atomic 2:1 flit merge; grant held head->tail; MERGE2_RR_EN selects round-robin, else In0 fixed priority.
// Latency: one cycle (registered output), one flit per cycle sustained.
// Backpressure: input ready only when the output register is empty or draining; Out_data held while stalled.
module merge2_arbiter #(
  parameter int W = 9
) (
  input logic          CLK,
  input logic          RESET,
  merge2_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           space;
  logic           grant;
  logic           rdy0;
  logic           rdy1;
  logic           xfer0;
  logic           xfer1;
  logic           load;
  logic [W-1:0]   flit;
  logic [W-1:0]   out_data_q;
  logic           out_valid_q;
`ifdef MERGE2_RR_EN
  logic           last;
`endif

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    rdy0      = 1'b0;
    rdy1      = 1'b0;
    space     = !out_valid_q || bus.Out_ready;
    case (state)
      IDLE: begin
        if (bus.In0_valid && bus.In1_valid) begin
`ifdef MERGE2_RR_EN
          grant = !last;
`else
          grant = 1'b0;
`endif
        end else begin
          grant = bus.In1_valid;
        end
        rdy0 = space && !grant;
        rdy1 = space && grant;
      end
      LOCK0:   rdy0 = space;
      LOCK1:   rdy1 = space;
      default: state_nxt = IDLE;
    endcase
    // Readys are combinational, so they must be masked while reset is held.
    if (RESET) begin
      rdy0 = 1'b0;
      rdy1 = 1'b0;
    end
    xfer0 = bus.In0_valid && rdy0;
    xfer1 = bus.In1_valid && rdy1;
    load  = xfer0 || xfer1;
    flit  = xfer1 ? bus.In1_data : bus.In0_data;
    if (load) begin
      if (flit[W-1]) state_nxt = IDLE;
      else           state_nxt = xfer1 ? LOCK1 : LOCK0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        out_data_q  <= flit;
        out_valid_q <= 1'b1;
      end else if (bus.Out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef MERGE2_RR_EN
  // Pointer moves only on a completed packet, so In0 wins the first contention after reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                  last <= 1'b1;
    else if (load && flit[W-1]) last <= xfer1;
  end
`endif

  assign bus.In0_ready = rdy0;
  assign bus.In1_ready = rdy1;
  assign bus.Out_data  = out_data_q;
  assign bus.Out_valid = out_valid_q;
  assign bus.Locked    = (state != IDLE);

endmodule

// File: tb/tb_merge2_arbiter.sv
// Directed bench for merge2_arbiter: per-cycle vector table plus hand sequences for contention and mid-packet reset.
`timescale 1ns/1ps
module tb_merge2_arbiter;
  localparam int W = 9;

  logic CLK;
  logic RESET;
  merge2_arbiter_if #(.W(W)) bus ();

  merge2_arbiter #(.W(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic         rst;
    logic         v0;
    logic [W-1:0] d0;
    logic         v1;
    logic [W-1:0] d1;
    logic         ordy;
    logic         ovld;
    logic [W-1:0] odat;
    logic         r0;
    logic         r1;
    logic         lk;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(logic rst, logic v0, logic [W-1:0] d0, logic v1, logic [W-1:0] d1,
                              logic ordy, logic ovld, logic [W-1:0] odat, logic r0, logic r1, logic lk);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
    v.ovld = ovld; v.odat = odat; v.r0 = r0; v.r1 = r1; v.lk = lk;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic v0, input logic [W-1:0] d0,
                       input logic v1, input logic [W-1:0] d1, input logic ordy);
    @(negedge CLK);
    RESET         = rst;
    bus.In0_valid = v0;
    bus.In0_data  = d0;
    bus.In1_valid = v1;
    bus.In1_data  = d1;
    bus.Out_ready = ordy;
    #1;
  endtask

  task automatic check_all(input string tag, input logic ovld, input logic [W-1:0] odat,
                           input logic r0, input logic r1, input logic lk);
    check({tag, ".out_valid"}, 32'(bus.Out_valid), 32'(ovld));
    if (ovld) check({tag, ".out_data"}, 32'(bus.Out_data), 32'(odat));
    check({tag, ".in0_ready"}, 32'(bus.In0_ready), 32'(r0));
    check({tag, ".in1_ready"}, 32'(bus.In1_ready), 32'(r1));
    check({tag, ".locked"}, 32'(bus.Locked), 32'(lk));
  endtask

  initial begin
    RESET = 1'b1;
    bus.In0_valid = 1'b0; bus.In0_data = '0;
    bus.In1_valid = 1'b0; bus.In1_data = '0;
    bus.Out_ready = 1'b0;

    //               rst v0 d0      v1 d1      ordy | ovld odat    r0 r1 lk
    // reset held with both valid, then release: In0 wins
    vecs[0]  = mk(1, 1, 9'h101, 1, 9'h1A1, 1,  0, 9'h000, 0, 0, 0);
    vecs[1]  = mk(1, 1, 9'h101, 1, 9'h1A1, 1,  0, 9'h000, 0, 0, 0);
    vecs[2]  = mk(0, 1, 9'h101, 1, 9'h1A1, 1,  0, 9'h000, 1, 0, 0);
    // In0 4-flit packet, In1 waiting
    vecs[3]  = mk(0, 1, 9'h011, 0, 9'h1A1, 1,  1, 9'h101, 1, 0, 0);
    vecs[4]  = mk(0, 1, 9'h012, 1, 9'h1A1, 1,  1, 9'h011, 1, 0, 1);
    vecs[5]  = mk(0, 1, 9'h013, 1, 9'h1A1, 1,  1, 9'h012, 1, 0, 1);
    vecs[6]  = mk(0, 1, 9'h114, 1, 9'h1A1, 1,  1, 9'h013, 1, 0, 1);
    vecs[7]  = mk(0, 0, 9'h000, 1, 9'h1A1, 1,  1, 9'h114, 0, 1, 0);
    vecs[8]  = mk(0, 0, 9'h000, 0, 9'h000, 1,  1, 9'h1A1, 1, 0, 0);
    // In1 3-flit packet with 3-cycle stall mid-packet, In0 waiting
    vecs[9]  = mk(0, 0, 9'h000, 1, 9'h0B1, 1,  0, 9'h1A1, 0, 1, 0);
    vecs[10] = mk(0, 1, 9'h121, 1, 9'h0B2, 1,  1, 9'h0B1, 0, 1, 1);
    vecs[11] = mk(0, 1, 9'h121, 1, 9'h1B3, 0,  1, 9'h0B2, 0, 0, 1);
    vecs[12] = mk(0, 1, 9'h121, 1, 9'h1B3, 0,  1, 9'h0B2, 0, 0, 1);
    vecs[13] = mk(0, 1, 9'h121, 1, 9'h1B3, 0,  1, 9'h0B2, 0, 0, 1);
    vecs[14] = mk(0, 1, 9'h121, 1, 9'h1B3, 1,  1, 9'h0B2, 0, 1, 1);
    vecs[15] = mk(0, 1, 9'h121, 0, 9'h000, 1,  1, 9'h1B3, 1, 0, 0);
    // output stalled with nothing pending, then drains
    vecs[16] = mk(0, 0, 9'h000, 0, 9'h000, 0,  1, 9'h121, 0, 0, 0);
    vecs[17] = mk(0, 0, 9'h000, 0, 9'h000, 1,  1, 9'h121, 1, 0, 0);
    vecs[18] = mk(0, 0, 9'h000, 0, 9'h000, 1,  0, 9'h121, 1, 0, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy);
      check_all($sformatf("vec%0d", i), vecs[i].ovld, vecs[i].odat, vecs[i].r0, vecs[i].r1, vecs[i].lk);
    end

    // Contention with single-flit packets: last completed packet came from In0.
    begin
      logic [W-1:0] f0;
      logic [W-1:0] f1;
      logic [W-1:0] prev;
      logic         g;
      int           n0;
      int           n1;
      n0 = 0; n1 = 0;
`ifdef MERGE2_RR_EN
      g = 1'b1;
`else
      g = 1'b0;
`endif
      prev = '0;
      for (int c = 0; c < 6; c++) begin
        f0 = 9'h140 | 9'(n0);
        f1 = 9'h180 | 9'(n1);
        drive(0, 1, f0, 1, f1, 1);
        check($sformatf("rr%0d.in0_ready", c), 32'(bus.In0_ready), 32'(!g));
        check($sformatf("rr%0d.in1_ready", c), 32'(bus.In1_ready), 32'(g));
        if (c > 0) check($sformatf("rr%0d.out_data", c), 32'(bus.Out_data), 32'(prev));
        prev = g ? f1 : f0;
        if (g) n1++; else n0++;
`ifdef MERGE2_RR_EN
        g = !g;
`endif
      end
      drive(0, 0, '0, 0, '0, 1);
      check("rr_last.out_data", 32'(bus.Out_data), 32'(prev));
      check("rr_last.out_valid", 32'(bus.Out_valid), 32'd1);
    end

    // Reset in the middle of an In1 5-flit packet (2 flits accepted).
    drive(0, 0, '0, 1, 9'h0C1, 1);
    check("rst_seq.h_ready1", 32'(bus.In1_ready), 32'd1);
    drive(0, 0, '0, 1, 9'h0C2, 1);
    check("rst_seq.locked", 32'(bus.Locked), 32'd1);
    drive(1, 1, 9'h131, 1, 9'h0C3, 1);
    check_all("rst_seq.during", 0, 9'h000, 0, 0, 0);
    drive(0, 1, 9'h131, 1, 9'h0C3, 1);
    check_all("rst_seq.after", 0, 9'h000, 1, 0, 0);
    drive(0, 0, '0, 1, 9'h0C3, 1);
    check_all("rst_seq.newhead", 1, 9'h131, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
